// File: rtl/slip_pix_pkg.sv
// Shared constants, types and helpers for the Slipstream pixel serialiser.
package slip_pix_pkg;

  localparam int unsigned DEF_WORD_W = 16;
  localparam int unsigned DEF_PIX_W4 = 4;
  localparam int unsigned DEF_PIX_W8 = 8;

  localparam int unsigned CNT_W = $clog2(DEF_WORD_W / DEF_PIX_W4);
  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    ACT_SHIFT,
    ACT_XFER,
    ACT_UNDER
  } pe_act_t;

  function automatic int unsigned pixels_per_word(
    input logic        mode8,
    input int unsigned word_w = DEF_WORD_W,
    input int unsigned pix_w4 = DEF_PIX_W4,
    input int unsigned pix_w8 = DEF_PIX_W8
  );
    return mode8 ? (word_w / pix_w8) : (word_w / pix_w4);
  endfunction

endpackage

// File: rtl/slip_pixel_serialiser_if.sv
// Word-in / pixel-out bundle between a Slipstream register cell and the serialiser.
interface slip_pixel_serialiser_if
  import slip_pix_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
);
  logic [WORD_W-1:0] d;
  logic              ld;
  logic              mode8;
  logic              clrUnderrun;
  logic              holdFull;
  logic [7:0]        pix;
  logic              pixValid;
  logic              underrun;

  modport master (
    output d, ld, mode8, clrUnderrun,
    input  holdFull, pix, pixValid, underrun
  );

  modport slave (
    input  d, ld, mode8, clrUnderrun,
    output holdFull, pix, pixValid, underrun
  );
endinterface

// File: rtl/slip_edge_detect.sv
// Rising-edge detector for a derived clock sampled on MasterClock.
module slip_edge_detect (
  input  logic MasterClock,
  input  logic resetL,
  input  logic clk,
  output logic pe
);
  logic r_oldClk;
  logic r_armed;

  // r_armed blocks the false edge seen when clk is already high at reset release;
  // a low sample of clk is required before any edge is reported.
  always_ff @(posedge MasterClock or negedge resetL) begin
    if (!resetL) begin
      r_oldClk <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_oldClk <= clk;
      r_armed  <= r_armed | ~clk;
    end
  end

  assign pe = r_armed & ~r_oldClk & clk;
endmodule

// File: rtl/slip_pixel_serialiser.sv
// Serialises 16-bit register-cell words into 4bpp/8bpp pixels, MSB first, via a one-word holding buffer.
module slip_pixel_serialiser
  import slip_pix_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned PIX_W4 = DEF_PIX_W4,
  parameter int unsigned PIX_W8 = DEF_PIX_W8
)(
  input  logic                    MasterClock,
  input  logic                    resetL,
  input  logic                    clk,
  slip_pixel_serialiser_if.slave  bus
);
  localparam int unsigned CNT_LW = $clog2(WORD_W / PIX_W4);

  logic [WORD_W-1:0] r_hold;
  logic              r_holdFull;
  logic [WORD_W-1:0] r_shifter;
  logic [CNT_LW-1:0] r_count;
  logic              r_wordMode;
  logic [7:0]        r_pix;
  logic              r_pixValid;
  logic              r_underrun;
  logic              r_loaded;

  logic              w_pe;
  pe_act_t           w_act;
  logic              w_load;
  logic [7:0]        w_sh_pix;
  logic [7:0]        w_hold_pix;
  logic [CNT_LW-1:0] w_xfer_count;

  slip_edge_detect u_edge (
    .MasterClock (MasterClock),
    .resetL      (resetL),
    .clk         (clk),
    .pe          (w_pe)
  );

  always_comb begin
    w_act = ACT_UNDER;
    if (r_count != '0)
      w_act = ACT_SHIFT;
    else if (r_holdFull)
      w_act = ACT_XFER;

    // The hold slot is freed by a transfer on the same edge, so back-to-back loads are accepted.
    w_load = bus.ld && (!r_holdFull || (w_act == ACT_XFER));

    w_sh_pix     = r_wordMode ? 8'(r_shifter[WORD_W-1 -: PIX_W8])
                              : 8'(r_shifter[WORD_W-1 -: PIX_W4]);
    w_hold_pix   = bus.mode8  ? 8'(r_hold[WORD_W-1 -: PIX_W8])
                              : 8'(r_hold[WORD_W-1 -: PIX_W4]);
    w_xfer_count = CNT_LW'(pixels_per_word(bus.mode8, WORD_W, PIX_W4, PIX_W8) - 1);
  end

  always_ff @(posedge MasterClock or negedge resetL) begin
    if (!resetL) begin
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_shifter  <= '0;
      r_count    <= '0;
      r_wordMode <= 1'b0;
      r_pix      <= '0;
      r_pixValid <= 1'b0;
      r_underrun <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      if (w_pe) begin
        unique case (w_act)
          ACT_SHIFT: begin
            r_pix      <= w_sh_pix;
            r_pixValid <= 1'b1;
            r_shifter  <= r_wordMode ? (r_shifter << PIX_W8) : (r_shifter << PIX_W4);
            r_count    <= r_count - 1'b1;
          end
          ACT_XFER: begin
            r_wordMode <= bus.mode8;
            r_pix      <= w_hold_pix;
            r_shifter  <= bus.mode8 ? (r_hold << PIX_W8) : (r_hold << PIX_W4);
            r_count    <= w_xfer_count;
            r_pixValid <= 1'b1;
            r_holdFull <= 1'b0;
          end
          default: begin
            r_pix      <= '0;
            r_pixValid <= 1'b0;
          end
        endcase

        if (w_load) begin
          r_hold     <= bus.d;
          r_holdFull <= 1'b1;
          r_loaded   <= 1'b1;
        end
      end

      // A fresh underrun takes priority over a simultaneous clear.
      if (w_pe && (w_act == ACT_UNDER) && r_loaded)
        r_underrun <= 1'b1;
      else if (bus.clrUnderrun)
        r_underrun <= 1'b0;
    end
  end

  assign bus.holdFull = r_holdFull;
  assign bus.pix      = r_pix;
  assign bus.pixValid = r_pixValid;
  assign bus.underrun = r_underrun;
endmodule

// File: tb/tb_slip_pixel_serialiser.sv
// Directed self-checking bench for slip_pixel_serialiser.
module tb_slip_pixel_serialiser;
  logic MasterClock;
  logic resetL;
  logic clk;

  int unsigned n_checks;
  int unsigned n_pass;

  slip_pixel_serialiser_if #(.WORD_W(16)) bus ();

  slip_pixel_serialiser #(
    .WORD_W (16),
    .PIX_W4 (4),
    .PIX_W8 (8)
  ) u_dut (
    .MasterClock (MasterClock),
    .resetL      (resetL),
    .clk         (clk),
    .bus         (bus)
  );

  initial MasterClock = 1'b0;
  always #5 MasterClock = ~MasterClock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One pixel-clock period: a low sample, then a rising edge; outputs sampled 1ns after the pe posedge.
  task automatic pedge(input logic l, input logic [15:0] dv, input logic clr);
    @(negedge MasterClock);
    clk = 1'b0; bus.ld = 1'b0; bus.clrUnderrun = 1'b0;
    @(negedge MasterClock);
    clk = 1'b1; bus.ld = l; bus.d = dv; bus.clrUnderrun = clr;
    @(posedge MasterClock);
    #1;
    bus.ld = 1'b0; bus.clrUnderrun = 1'b0;
  endtask

  task automatic clr_under();
    @(negedge MasterClock);
    bus.clrUnderrun = 1'b1;
    @(posedge MasterClock);
    #1;
    bus.clrUnderrun = 1'b0;
  endtask

  initial begin
    logic [7:0]  exp4 [4];
    logic [15:0] ovf_d [10];
    logic        ovf_ld [10];
    logic [7:0]  ovf_pix [10];
    logic        ovf_val [10];

    n_checks = 0; n_pass = 0;
    resetL = 1'b0; clk = 1'b0;
    bus.d = '0; bus.ld = 1'b0; bus.mode8 = 1'b0; bus.clrUnderrun = 1'b0;

    // Reset with clk toggling
    repeat (4) begin
      @(negedge MasterClock); clk = ~clk; bus.ld = 1'b1; bus.d = 16'hFFFF;
    end
    #1;
    check("rst_pix",      32'(bus.pix),      32'h0);
    check("rst_valid",    32'(bus.pixValid), 32'h0);
    check("rst_underrun", 32'(bus.underrun), 32'h0);
    check("rst_holdFull", 32'(bus.holdFull), 32'h0);

    // Release with clk high: no pe, so the pending ld must not load
    @(negedge MasterClock); clk = 1'b1;
    @(negedge MasterClock); resetL = 1'b1;
    repeat (3) @(posedge MasterClock);
    #1;
    check("rel_no_pe_hold", 32'(bus.holdFull), 32'h0);
    bus.ld = 1'b0;

    // Edge with nothing ever loaded: no underrun yet
    pedge(1'b0, 16'h0, 1'b0);
    check("first_word_no_underrun", 32'(bus.underrun), 32'h0);
    check("first_word_valid",       32'(bus.pixValid), 32'h0);

    // 4bpp stream 0xABCD
    bus.mode8 = 1'b0;
    pedge(1'b1, 16'hABCD, 1'b0);
    check("s4_load_hold",  32'(bus.holdFull), 32'h1);
    check("s4_load_valid", 32'(bus.pixValid), 32'h0);
    exp4 = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    for (int i = 0; i < 4; i++) begin
      pedge(1'b0, 16'h0, 1'b0);
      check($sformatf("s4_pix%0d", i),   32'(bus.pix),      32'(exp4[i]));
      check($sformatf("s4_valid%0d", i), 32'(bus.pixValid), 32'h1);
    end
    check("s4_no_early_underrun", 32'(bus.underrun), 32'h0);
    pedge(1'b0, 16'h0, 1'b0);
    check("s4_end_pix",      32'(bus.pix),      32'h0);
    check("s4_end_valid",    32'(bus.pixValid), 32'h0);
    check("s4_end_underrun", 32'(bus.underrun), 32'h1);
    clr_under();
    check("s4_clr_underrun", 32'(bus.underrun), 32'h0);

    // 8bpp back-to-back
    bus.mode8 = 1'b1;
    pedge(1'b1, 16'h1234, 1'b0);
    check("s8_pe0_hold", 32'(bus.holdFull), 32'h1);
    pedge(1'b1, 16'h5678, 1'b0);
    check("s8_pe1_pix",  32'(bus.pix),      32'h12);
    check("s8_pe1_hold", 32'(bus.holdFull), 32'h1);
    pedge(1'b0, 16'h0, 1'b0);
    check("s8_pe2_pix",  32'(bus.pix),      32'h34);
    check("s8_pe2_val",  32'(bus.pixValid), 32'h1);
    pedge(1'b0, 16'h0, 1'b0);
    check("s8_pe3_pix",  32'(bus.pix),      32'h56);
    check("s8_pe3_hold", 32'(bus.holdFull), 32'h0);
    pedge(1'b0, 16'h0, 1'b0);
    check("s8_pe4_pix",  32'(bus.pix),      32'h78);
    clr_under();
    pedge(1'b0, 16'h0, 1'b0);
    check("s8_pe5_valid",    32'(bus.pixValid), 32'h0);
    check("s8_pe5_underrun", 32'(bus.underrun), 32'h1);

    // Overflow drop in 4bpp: 0x3333 arrives while hold is full and no transfer occurs
    bus.mode8 = 1'b0;
    ovf_d   = '{16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    ovf_ld  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ovf_pix = '{8'h0, 8'h1, 8'h1, 8'h1, 8'h1, 8'h2, 8'h2, 8'h2, 8'h2, 8'h0};
    ovf_val = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      pedge(ovf_ld[i], ovf_d[i], 1'b0);
      check($sformatf("ovf_pix%0d", i), 32'(bus.pix),      32'(ovf_pix[i]));
      check($sformatf("ovf_val%0d", i), 32'(bus.pixValid), 32'(ovf_val[i]));
      if (i == 2) check("ovf_hold_kept", 32'(bus.holdFull), 32'h1);
      if (i == 5) check("ovf_hold_empty", 32'(bus.holdFull), 32'h0);
    end

    // mode8 raised mid-word: remaining pixels stay 4bpp
    bus.mode8 = 1'b0;
    pedge(1'b1, 16'hABCD, 1'b0);
    pedge(1'b0, 16'h0, 1'b0);
    check("mm_pix0", 32'(bus.pix), 32'h0A);
    bus.mode8 = 1'b1;
    for (int i = 1; i < 4; i++) begin
      pedge(1'b0, 16'h0, 1'b0);
      check($sformatf("mm_pix%0d", i), 32'(bus.pix), 32'(exp4[i]));
    end
    pedge(1'b0, 16'h0, 1'b0);
    check("mm_end_valid", 32'(bus.pixValid), 32'h0);
    bus.mode8 = 1'b0;

    // clrUnderrun coincident with a fresh underrun: set wins
    clr_under();
    check("cu_cleared", 32'(bus.underrun), 32'h0);
    pedge(1'b0, 16'h0, 1'b1);
    check("cu_set_wins", 32'(bus.underrun), 32'h1);
    clr_under();
    check("cu_clear_non_pe", 32'(bus.underrun), 32'h0);

    // Async reset mid-word
    pedge(1'b1, 16'hABCD, 1'b0);
    pedge(1'b0, 16'h0, 1'b0);
    pedge(1'b0, 16'h0, 1'b0);
    check("ar_pre_pix", 32'(bus.pix), 32'h0B);
    #3 resetL = 1'b0;
    #1;
    check("ar_pix",   32'(bus.pix),      32'h0);
    check("ar_valid", 32'(bus.pixValid), 32'h0);
    check("ar_hold",  32'(bus.holdFull), 32'h0);
    @(negedge MasterClock); resetL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pedge(1'b0, 16'h0, 1'b0);
      check($sformatf("ar_after_pix%0d", i), 32'(bus.pix),      32'h0);
      check($sformatf("ar_after_val%0d", i), 32'(bus.pixValid), 32'h0);
    end
    check("ar_after_underrun", 32'(bus.underrun), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
